// File: rtl/bus_arbiter_n.sv
// Purpose: serialises NUM_PORTS request channels onto one shared bus master port (round-robin or fixed priority).
// Latency: i_req in IDLE -> o_bus_en next cycle; i_ack -> o_ack next cycle -> IDLE the cycle after (3-cycle minimum period).
// Backpressure: one transfer outstanding; other requesters wait with i_req held; optional ack timeout answers with o_err.
module bus_arbiter_n #(
    parameter int NUM_PORTS = 4,
    parameter int XLEN      = 32,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_PORTS-1:0]          i_req,
    input  logic [NUM_PORTS-1:0]          i_wr_en,
    input  logic [NUM_PORTS*XLEN-1:0]     i_addr,
    input  logic [NUM_PORTS*XLEN-1:0]     i_wr_data,
    input  logic [NUM_PORTS*XLEN/8-1:0]   i_byte_en,
    output logic [NUM_PORTS-1:0]          o_ack,
    output logic [NUM_PORTS-1:0]          o_err,
    output logic [XLEN-1:0]               o_rd_data,
    output logic [$clog2(NUM_PORTS)-1:0]  o_grant_id,
    output logic                          o_bus_en,
    output logic                          o_wr_en,
    output logic [XLEN-1:0]               o_addr,
    output logic [XLEN-1:0]               o_wr_data,
    output logic [XLEN/8-1:0]             o_byte_en,
    input  logic                          i_ack,
    input  logic [XLEN-1:0]               i_rd_data
);

    localparam int GW = $clog2(NUM_PORTS);
    localparam int BW = XLEN / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [GW-1:0]         r_ptr;
    logic [CW-1:0]         r_cnt;
    logic [GW-1:0]         r_grant;
    logic                  r_bus_en;
    logic                  r_wr_en;
    logic [XLEN-1:0]       r_addr;
    logic [XLEN-1:0]       r_wr_data;
    logic [BW-1:0]         r_byte_en;
    logic [NUM_PORTS-1:0]  r_ack;
    logic [NUM_PORTS-1:0]  r_err;
    logic [XLEN-1:0]       r_rd_data;

    state_t                w_state_nxt;
    logic [GW-1:0]         w_ptr_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [GW-1:0]         w_grant_nxt;
    logic                  w_bus_en_nxt;
    logic                  w_wr_en_nxt;
    logic [XLEN-1:0]       w_addr_nxt;
    logic [XLEN-1:0]       w_wr_data_nxt;
    logic [BW-1:0]         w_byte_en_nxt;
    logic [NUM_PORTS-1:0]  w_ack_nxt;
    logic [NUM_PORTS-1:0]  w_err_nxt;
    logic [XLEN-1:0]       w_rd_data_nxt;

    logic [GW-1:0]         w_win;
    logic                  w_found;
    logic                  w_any;
    logic                  w_timeout;

    assign w_any     = |i_req;
    assign w_timeout = (TIMEOUT > 0) && (int'(r_cnt) == TIMEOUT - 1);

    // Winner selection: rotating search after the last grant, or lowest index in fixed mode.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        if (PRIO_MODE != 0) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (i_req[i]) begin
                    w_win = GW'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!w_found && i_req[(int'(r_ptr) + 1 + i) % NUM_PORTS]) begin
                    w_win   = GW'((int'(r_ptr) + 1 + i) % NUM_PORTS);
                    w_found = 1'b1;
                end
            end
        end
    end

    // Next-state and next-output logic for the IDLE/BUSY/RESP sequence.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_grant_nxt   = r_grant;
        w_bus_en_nxt  = r_bus_en;
        w_wr_en_nxt   = r_wr_en;
        w_addr_nxt    = r_addr;
        w_wr_data_nxt = r_wr_data;
        w_byte_en_nxt = r_byte_en;
        w_ack_nxt     = '0;
        w_err_nxt     = '0;
        w_rd_data_nxt = r_rd_data;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_nxt   = w_win;
                    w_ptr_nxt     = w_win;
                    w_cnt_nxt     = '0;
                    w_bus_en_nxt  = 1'b1;
                    w_wr_en_nxt   = i_wr_en[w_win];
                    w_addr_nxt    = i_addr[int'(w_win)*XLEN +: XLEN];
                    w_wr_data_nxt = i_wr_data[int'(w_win)*XLEN +: XLEN];
                    w_byte_en_nxt = i_byte_en[int'(w_win)*BW +: BW];
                    w_state_nxt   = BUSY;
                end
            end
            BUSY: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (i_ack) begin
                    w_rd_data_nxt      = r_wr_en ? '0 : i_rd_data;
                    w_ack_nxt[r_grant] = 1'b1;
                    w_bus_en_nxt       = 1'b0;
                    w_state_nxt        = RESP;
                end else if (w_timeout) begin
                    w_rd_data_nxt      = '0;
                    w_ack_nxt[r_grant] = 1'b1;
                    w_err_nxt[r_grant] = 1'b1;
                    w_bus_en_nxt       = 1'b0;
                    w_state_nxt        = RESP;
                end
            end
            RESP: begin
                // Pulse ends here; read data is only meaningful alongside o_ack.
                w_rd_data_nxt = '0;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_state_nxt  = IDLE;
                w_bus_en_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transfer silently.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_ptr     <= GW'(NUM_PORTS - 1);
            r_cnt     <= '0;
            r_grant   <= '0;
            r_bus_en  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_byte_en <= '0;
            r_ack     <= '0;
            r_err     <= '0;
            r_rd_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_bus_en  <= w_bus_en_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_addr    <= w_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_byte_en <= w_byte_en_nxt;
            r_ack     <= w_ack_nxt;
            r_err     <= w_err_nxt;
            r_rd_data <= w_rd_data_nxt;
        end
    end

    assign o_ack      = r_ack;
    assign o_err      = r_err;
    assign o_rd_data  = r_rd_data;
    assign o_grant_id = r_grant;
    assign o_bus_en   = r_bus_en;
    assign o_wr_en    = r_wr_en;
    assign o_addr     = r_addr;
    assign o_wr_data  = r_wr_data;
    assign o_byte_en  = r_byte_en;

endmodule

// File: tb/tb_bus_arbiter_n.sv
`timescale 1ns/1ps
module tb_bus_arbiter_n;

    localparam int N    = 4;
    localparam int XLEN = 32;
    localparam int TO   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_rr, req_fx, wr_en;
    logic [N*XLEN-1:0] addr, wdata;
    logic [N*4-1:0]    be;
    logic              ack_in;
    logic [XLEN-1:0]   rdata_in;

    logic [N-1:0]      rr_ack, rr_err, fx_ack, fx_err;
    logic [XLEN-1:0]   rr_rd, fx_rd, rr_addr, fx_addr, rr_wd, fx_wd;
    logic [1:0]        rr_gid, fx_gid;
    logic              rr_bus, fx_bus, rr_we, fx_we;
    logic [3:0]        rr_be, fx_be;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int              ptr_rr;
    logic [N-1:0]    pend_rr, pend_fx;
    logic [31:0]     f_addr [N];
    logic [31:0]     f_wd   [N];
    logic [3:0]      f_be   [N];
    logic            f_we   [N];
    int              order  [5];
    int              gr, gf;

    always #5 clk = ~clk;

    bus_arbiter_n #(.NUM_PORTS(N), .XLEN(XLEN), .PRIO_MODE(0), .TIMEOUT(TO)) u_rr (
        .i_clk(clk), .i_rst(rst), .i_req(req_rr), .i_wr_en(wr_en), .i_addr(addr),
        .i_wr_data(wdata), .i_byte_en(be), .o_ack(rr_ack), .o_err(rr_err),
        .o_rd_data(rr_rd), .o_grant_id(rr_gid), .o_bus_en(rr_bus), .o_wr_en(rr_we),
        .o_addr(rr_addr), .o_wr_data(rr_wd), .o_byte_en(rr_be), .i_ack(ack_in),
        .i_rd_data(rdata_in)
    );

    bus_arbiter_n #(.NUM_PORTS(N), .XLEN(XLEN), .PRIO_MODE(1), .TIMEOUT(TO)) u_fx (
        .i_clk(clk), .i_rst(rst), .i_req(req_fx), .i_wr_en(wr_en), .i_addr(addr),
        .i_wr_data(wdata), .i_byte_en(be), .o_ack(fx_ack), .o_err(fx_err),
        .o_rd_data(fx_rd), .o_grant_id(fx_gid), .o_bus_en(fx_bus), .o_wr_en(fx_we),
        .o_addr(fx_addr), .o_wr_data(fx_wd), .o_byte_en(fx_be), .i_ack(ack_in),
        .i_rd_data(rdata_in)
    );

    function automatic int rr_pick(input int p, input logic [N-1:0] m);
        for (int j = 1; j <= N; j++) begin
            if (m[(p + j) % N]) return (p + j) % N;
        end
        return -1;
    endfunction

    function automatic int fx_pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[k]) return k;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_fields();
        for (int k = 0; k < N; k++) begin
            f_addr[k] = $urandom;
            f_wd[k]   = $urandom;
            f_be[k]   = 4'($urandom);
            f_we[k]   = 1'($urandom);
        end
    endtask

    task automatic drive_fields();
        for (int k = 0; k < N; k++) begin
            addr[k*XLEN +: XLEN]  = f_addr[k];
            wdata[k*XLEN +: XLEN] = f_wd[k];
            be[k*4 +: 4]          = f_be[k];
            wr_en[k]              = f_we[k];
        end
    endtask

    task automatic scramble();
        addr  = {$urandom, $urandom, $urandom, $urandom};
        wdata = {$urandom, $urandom, $urandom, $urandom};
        be    = 16'($urandom);
        wr_en = 4'($urandom);
    endtask

    // One complete transaction on both arbiters; dly = BUSY cycles before i_ack, to_en = never ack.
    task automatic xfer(input int dly, input bit to_en, input logic [31:0] rd_val,
                        output int o_gr, output int o_gf);
        int wr, wf;
        bit done;
        logic [3:0]  oh_r, oh_f, er_r, er_f;
        logic [31:0] exp_rd_r, exp_rd_f;
        wr = rr_pick(ptr_rr, pend_rr);
        wf = fx_pick(pend_fx);
        drive_fields();
        req_rr = pend_rr;
        req_fx = pend_fx;
        ack_in = 1'b0;
        tick();
        ptr_rr = wr;
        check("rr_grant", 64'(rr_gid), 64'(wr));
        check("fx_grant", 64'(fx_gid), 64'(wf));
        check("bus_en_up", {rr_bus, fx_bus}, 2'b11);
        check("rr_addr", rr_addr, f_addr[wr]);
        check("fx_addr", fx_addr, f_addr[wf]);
        check("rr_we_be_wd", {rr_we, rr_be, rr_wd}, {f_we[wr], f_be[wr], f_wd[wr]});
        check("fx_we_be_wd", {fx_we, fx_be, fx_wd}, {f_we[wf], f_be[wf], f_wd[wf]});
        oh_r     = 4'(1 << wr);
        oh_f     = 4'(1 << wf);
        er_r     = to_en ? oh_r : 4'b0;
        er_f     = to_en ? oh_f : 4'b0;
        exp_rd_r = (to_en || f_we[wr]) ? 32'h0 : rd_val;
        exp_rd_f = (to_en || f_we[wf]) ? 32'h0 : rd_val;
        for (int c = 0; c < TO; c++) begin
            done     = to_en ? (c == TO - 1) : (c == dly);
            ack_in   = !to_en && (c == dly);
            rdata_in = rd_val;
            scramble();
            tick();
            ack_in = 1'b0;
            if (done) begin
                check("rr_done", {rr_bus, rr_ack, rr_err}, {1'b0, oh_r, er_r});
                check("fx_done", {fx_bus, fx_ack, fx_err}, {1'b0, oh_f, er_f});
                check("rr_rd_data", rr_rd, exp_rd_r);
                check("fx_rd_data", fx_rd, exp_rd_f);
                break;
            end
            check("busy_hold", {rr_bus, fx_bus, rr_ack, fx_ack}, {2'b11, 8'h0});
            check("busy_stable", {rr_addr, rr_wd}, {f_addr[wr], f_wd[wr]});
        end
        pend_rr[wr] = 1'b0;
        pend_fx[wf] = 1'b0;
        req_rr = pend_rr;
        req_fx = pend_fx;
        tick();
        check("resp_clear", {rr_ack, rr_err, fx_ack, fx_err, rr_bus, fx_bus}, 18'h0);
        check("grant_hold", {rr_gid, fx_gid}, {2'(wr), 2'(wf)});
        o_gr = wr;
        o_gf = wf;
    endtask

    initial begin
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        rst = 1'b1; req_rr = '0; req_fx = '0; ack_in = 1'b0; rdata_in = '0;
        addr = '0; wdata = '0; be = '0; wr_en = '0;
        pend_rr = '0; pend_fx = '0; ptr_rr = N - 1;
        randomize_fields();
        tick();
        tick();
        check("rst_ctrl", {rr_bus, rr_ack, rr_err, rr_gid, fx_bus, fx_ack, fx_err}, 20'h0);
        check("rst_data", {rr_rd, rr_addr}, 64'h0);
        rst = 1'b0;
        tick();

        // stray ack while idle
        ack_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray_ack", {rr_ack, fx_ack, rr_bus, fx_bus}, 10'h0);
        end
        ack_in = 1'b0;

        // round-robin fairness and fixed priority in parallel
        for (int i = 0; i < 5; i++) begin
            pend_rr = 4'hF;
            pend_fx = 4'b1010;
            randomize_fields();
            xfer(0, 1'b0, $urandom, gr, gf);
            check("rr_order", 64'(gr), 64'(order[i]));
            check("fx_prio", 64'(gf), 64'd1);
        end
        pend_rr = 4'hF;
        pend_fx = 4'b1000;
        randomize_fields();
        xfer(0, 1'b0, $urandom, gr, gf);
        check("fx_after_drop", 64'(gf), 64'd3);

        // single read from port 0, ack in third BUSY cycle
        pend_rr = 4'b0001;
        pend_fx = 4'b0001;
        randomize_fields();
        f_addr[0] = 32'h100;
        f_we[0]   = 1'b0;
        xfer(2, 1'b0, 32'hDEADBEEF, gr, gf);

        // write from port 3 with fields scrambled during BUSY
        pend_rr = 4'b1000;
        pend_fx = 4'b1000;
        randomize_fields();
        f_we[3] = 1'b1;
        f_wd[3] = 32'h12345678;
        f_be[3] = 4'b0011;
        xfer(1, 1'b0, $urandom, gr, gf);

        // timeout on port 2
        pend_rr = 4'b0100;
        pend_fx = 4'b0100;
        randomize_fields();
        xfer(0, 1'b1, $urandom | 32'h1, gr, gf);

        // reset in the middle of a transfer
        pend_rr = 4'b0010;
        pend_fx = 4'b0010;
        randomize_fields();
        drive_fields();
        req_rr = pend_rr;
        req_fx = pend_fx;
        tick();
        check("pre_rst_busy", {rr_bus, fx_bus}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ctrl", {rr_bus, rr_ack, rr_gid, rr_we, rr_be, fx_bus, fx_gid}, 16'h0);
        check("async_rst_data", {rr_addr, rr_wd}, 64'h0);
        req_rr = '0;
        req_fx = '0;
        tick();
        rst = 1'b0;
        pend_rr = '0;
        pend_fx = '0;
        ptr_rr = N - 1;
        tick();
        check("post_rst_quiet", {rr_ack, fx_ack, rr_bus, fx_bus}, 10'h0);
        pend_rr = 4'b0110;
        pend_fx = 4'b0110;
        randomize_fields();
        xfer(0, 1'b0, $urandom, gr, gf);
        pend_rr = 4'b0100;
        pend_fx = 4'b0100;
        randomize_fields();
        xfer(0, 1'b0, $urandom, gr, gf);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            pend_rr = pend_rr | 4'($urandom);
            pend_fx = pend_fx | 4'($urandom);
            if (pend_rr == '0) pend_rr[$urandom_range(0, N-1)] = 1'b1;
            if (pend_fx == '0) pend_fx[$urandom_range(0, N-1)] = 1'b1;
            randomize_fields();
            xfer($urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom, gr, gf);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_n.md
Name: bus_arbiter_n

Overview:
Parametrised N-master bus arbiter: the multi-hart successor to the single-core IM/DM bus mux. It collects NUM_PORTS independent request channels (e.g. IM and DM ports of several harts) and serialises them onto one shared bus master port. Grant is round-robin or fixed-priority, with one outstanding transfer, registered bus outputs and an optional ack timeout with error response. It sits between the hart bus adapters and the system bus slave.

Parameters:
NUM_PORTS, 4, number of requester channels (>=2).
XLEN, 32, address/data width.
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, lowest index wins.
TIMEOUT, 0, max BUSY cycles waiting for i_ack before an error response; 0 disables the timeout.

Ports:
i_clk  in  1  clock.
i_rst  in  1  asynchronous, active-high reset.
i_req  in  NUM_PORTS  per-channel request; held until that channel's o_ack.
i_wr_en  in  NUM_PORTS  per-channel write (1) / read (0).
i_addr  in  NUM_PORTS*XLEN  per-channel address, channel k at bits [k*XLEN +: XLEN].
i_wr_data  in  NUM_PORTS*XLEN  per-channel write data.
i_byte_en  in  NUM_PORTS*XLEN/8  per-channel byte enables.
o_ack  out  NUM_PORTS  one-cycle completion pulse to the granted channel.
o_err  out  NUM_PORTS  set together with o_ack on timeout.
o_rd_data  out  XLEN  read data; valid only while o_ack is high.
o_grant_id  out  $clog2(NUM_PORTS)  index of the current or most recent grant.
o_bus_en  out  1  bus transfer active.
o_wr_en, o_addr, o_wr_data, o_byte_en  out  1/XLEN/XLEN/XLEN/8  latched transfer fields.
i_ack  in  1  bus slave completion.
i_rd_data  in  XLEN  bus slave read data; sampled when i_ack is high.

Behaviour:
- Reset (async, any time, including mid-transfer): state=IDLE. All outputs are 0. RR pointer = NUM_PORTS-1, so port 0 has first priority. The in-flight transfer is discarded with no o_ack.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any i_req bit is high, pick winner g, latch its wr_en/addr/wr_data/byte_en into the output regs, set o_grant_id=g and o_bus_en=1, then go to BUSY. Otherwise stay in IDLE.
- Arbitration, RR mode: search from pointer+1 upward, wrapping modulo NUM_PORTS. The pointer updates to g only on grant.
- Arbitration, fixed mode: lowest set index wins.
- BUSY: bus outputs are held stable. When i_ack=1: capture i_rd_data into o_rd_data, set o_ack[g]=1, clear o_bus_en, go to RESP.
- BUSY timeout: with TIMEOUT>0, the cycle counter starts at 0 on entry to BUSY. If it reaches TIMEOUT-1 with no i_ack: clear o_bus_en, set o_ack[g]=1, o_err[g]=1, o_rd_data=0, go to RESP.
- RESP: the o_ack/o_err pulse is visible for exactly this one cycle. Both clear on the next edge, and the state returns to IDLE. No arbitration happens in RESP, so a requester that drops i_req on the edge ending RESP is never re-granted.
- Latency: i_req sampled in IDLE at cycle 0 gives o_bus_en at cycle 1. i_ack at cycle k gives o_ack at cycle k+1 and IDLE at cycle k+2. Minimum back-to-back period is 3 cycles when i_ack arrives in the first BUSY cycle.
- i_ack while in IDLE or RESP is ignored.
- Changes to i_* fields after grant do not affect the bus. Dropping i_req before o_ack is illegal; the transfer still completes.
- o_grant_id holds its value after RESP until the next grant.
- Only one channel's o_ack bit is ever high. o_rd_data is 0 when the completed transfer was a write.

Test Plan:
- Single read: i_req=4'b0001, addr=0x100, then i_ack at BUSY cycle 2 with rd_data=0xDEADBEEF -> o_bus_en cycles 1-3, o_addr=0x100, o_ack=4'b0001 at cycle 4 with o_rd_data=0xDEADBEEF, state IDLE at cycle 5.
- RR fairness: i_req=4'b1111 held and re-raised after each ack, immediate acks -> grant order 0,1,2,3,0; no port granted twice before all others.
- Fixed priority (PRIO_MODE=1): i_req=4'b1010 held -> port 1 granted repeatedly; port 3 is granted only after port 1 drops its request.
- Timeout (TIMEOUT=8): grant port 2, never assert i_ack -> o_bus_en low after 8 BUSY cycles, o_ack=o_err=4'b0100 for one cycle, o_rd_data=0.
- Reset mid-transfer: assert i_rst during BUSY with o_bus_en=1 -> all outputs 0 immediately (asynchronously). After release, a fresh i_req=4'b0100 is granted with RR starting at port 0.
- Stray ack and write: i_ack=1 while IDLE -> no o_ack. Write from port 3 (wr_data=0x12345678, byte_en=4'b0011) -> bus fields match exactly and stay stable while i_wr_data changes during BUSY.
